// File: rtl/xseq_player_pkg.sv
// Shared definitions for the sequence player: register map, CTRL/STATUS bit positions,
// FSM state encoding and the symbol-to-LED one-hot helper.
package xseq_player_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_LEN    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_APPEND = 1;
   localparam int CTRL_CLEAR  = 2;
   localparam int CTRL_LOOP   = 3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_FULL = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   function automatic logic [7:0] sym_onehot(input logic [2:0] s);
      sym_onehot = 8'b1 << s;
   endfunction

endpackage

// File: rtl/xseq_player_if.sv
// Register bus plus CPU LED request channel between the host side and the player.
// master = host/decoder side, slave = player side.
interface xseq_player_if;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       cpu_led_we;
   logic [7:0] cpu_led_data;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, cpu_led_we, cpu_led_data,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, cpu_led_we, cpu_led_data,
      output cfg_rdata
   );
endinterface

// File: rtl/xtick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks, restartable from zero via clr.
// Latency: first tick TICK_DIV cycles after clr.
// Backpressure: none, free-running.
module xtick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/xseq_player.sv
// Symbol sequence player: records lfsr symbols, replays them as one-hot LED loads.
// Latency: LED load strobe one cycle after each phase entry; CPU LED writes pass through same cycle in IDLE.
// Backpressure: none; CPU LED writes dropped while busy. Optional loop mode: XSEQ_LOOP_EN.
module xseq_player
   import xseq_player_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int TICK_DIV  = 50000,
   parameter int ON_TICKS  = 8,
   parameter int OFF_TICKS = 4
) (
   input  logic               clk,
   input  logic               rst,
   xseq_player_if.slave       cfg,
   input  logic [2:0]         lfsr_in,
   output logic               led_sel,
   output logic [7:0]         led_data,
   output logic               busy,
   output logic               done
);
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
   localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

   state_t          state_q, state_nx;
   logic [LW-1:0]   len_q, len_nx, len_c;
   logic [LW-1:0]   idx_q, idx_nx, idx_inc;
   logic [TW-1:0]   tcnt_q, tcnt_nx;
   logic            done_q, done_nx;
   logic            psel_q, psel_nx;
   logic [7:0]      pdat_q, pdat_nx;
   logic            enter, tick, ctrl_wr, clr_wr, run, sym_we, cpu_pass;
   logic [2:0]      sym_first;
   logic [2:0]      sym_mem [DEPTH];
   logic            unused_wdata;
`ifdef XSEQ_LOOP_EN
   logic            loop_q, loop_nx;
`endif

   assign ctrl_wr  = cfg.cfg_we && (cfg.cfg_addr == ADDR_CTRL);
   assign clr_wr   = ctrl_wr && cfg.cfg_wdata[CTRL_CLEAR];
   assign busy     = (state_q != ST_IDLE);
   // CLEAR is applied first, so APPEND/START in the same write see an idle, empty player.
   assign run      = busy && !clr_wr;
   assign len_c    = clr_wr ? '0 : len_q;
   assign idx_inc  = idx_q + 1'b1;
   assign sym_we   = ctrl_wr && cfg.cfg_wdata[CTRL_APPEND] && !run && (len_c != LEN_FULL);
   assign sym_first = (sym_we && (len_c == '0)) ? lfsr_in : sym_mem[0];
   assign unused_wdata = ^cfg.cfg_wdata[7:CTRL_LOOP];

   always_ff @(posedge clk) begin
      if (sym_we) begin
         sym_mem[len_c[AW-1:0]] <= lfsr_in;
      end
   end

   xtick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (enter),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         tcnt_q  <= '0;
         done_q  <= 1'b0;
         psel_q  <= 1'b0;
         pdat_q  <= '0;
`ifdef XSEQ_LOOP_EN
         loop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_nx;
         len_q   <= len_nx;
         idx_q   <= idx_nx;
         tcnt_q  <= tcnt_nx;
         done_q  <= done_nx;
         psel_q  <= psel_nx;
         pdat_q  <= pdat_nx;
`ifdef XSEQ_LOOP_EN
         loop_q  <= loop_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state_q;
      len_nx   = len_c;
      idx_nx   = idx_q;
      tcnt_nx  = tcnt_q;
      done_nx  = done_q;
      psel_nx  = 1'b0;
      pdat_nx  = '0;
      enter    = 1'b0;
`ifdef XSEQ_LOOP_EN
      loop_nx  = loop_q;
`endif
      if (clr_wr) begin
         done_nx = 1'b0;
         if (busy) begin
            state_nx = ST_IDLE;
            psel_nx  = 1'b1;
            enter    = 1'b1;
         end
      end
      if (sym_we) begin
         len_nx = len_c + 1'b1;
      end
      if (run) begin
         case (state_q)
            ST_ON: begin
               if (tick) begin
                  if (tcnt_q == ON_LAST) begin
                     state_nx = ST_OFF;
                     psel_nx  = 1'b1;
                     enter    = 1'b1;
                  end else begin
                     tcnt_nx = tcnt_q + 1'b1;
                  end
               end
            end
            ST_OFF: begin
               if (tick) begin
                  if (tcnt_q == OFF_LAST) begin
                     enter = 1'b1;
                     if (idx_q == len_q - 1'b1) begin
                        state_nx = ST_FIN;
                     end else begin
                        state_nx = ST_ON;
                        idx_nx   = idx_inc;
                        psel_nx  = 1'b1;
                        pdat_nx  = sym_onehot(sym_mem[idx_inc[AW-1:0]]);
                     end
                  end else begin
                     tcnt_nx = tcnt_q + 1'b1;
                  end
               end
            end
            ST_FIN: begin
               enter = 1'b1;
`ifdef XSEQ_LOOP_EN
               if (loop_q) begin
                  state_nx = ST_ON;
                  idx_nx   = '0;
                  psel_nx  = 1'b1;
                  pdat_nx  = sym_onehot(sym_mem[0]);
               end else begin
                  state_nx = ST_IDLE;
                  done_nx  = 1'b1;
               end
`else
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
`endif
            end
            default: ;
         endcase
      end else if (ctrl_wr && cfg.cfg_wdata[CTRL_START]) begin
         done_nx = 1'b0;
         idx_nx  = '0;
         enter   = 1'b1;
`ifdef XSEQ_LOOP_EN
         loop_nx = cfg.cfg_wdata[CTRL_LOOP];
`endif
         if (len_nx != '0) begin
            state_nx = ST_ON;
            psel_nx  = 1'b1;
            pdat_nx  = sym_onehot(sym_first);
         end else begin
            state_nx = ST_FIN;
         end
      end
      if (enter) begin
         tcnt_nx = '0;
      end
   end

   // Player loads beat CPU writes; the CPU path is only open while idle and out of reset.
   assign cpu_pass = rst && !busy && cfg.cpu_led_we;
   assign led_sel  = psel_q || cpu_pass;
   assign led_data = psel_q ? pdat_q : (cpu_pass ? cfg.cpu_led_data : 8'h00);
   assign done     = done_q;

   always_comb begin
      cfg.cfg_rdata = '0;
      case (cfg.cfg_addr)
         ADDR_LEN: cfg.cfg_rdata = 8'(len_q);
         ADDR_STATUS: begin
            cfg.cfg_rdata[STAT_BUSY] = busy;
            cfg.cfg_rdata[STAT_DONE] = done_q;
            cfg.cfg_rdata[STAT_FULL] = (len_q == LEN_FULL);
         end
         ADDR_CTRL, ADDR_RSVD: cfg.cfg_rdata = '0;
         default: ;
      endcase
   end
endmodule

// File: doc/xseq_player.md
XSEQ_PLAYER -- requirements
Module: xseq_player

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, sequence capacity in symbols (power of 2); TICK_DIV, default 50000, clk cycles per tick; ON_TICKS, default 8, ticks a symbol is lit; OFF_TICKS, default 4, dark ticks after each symbol.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- cfg_we  in  1  register write strobe from the address decoder.
- cfg_addr  in  2  register select.
- cfg_wdata  in  8  register write data.
- cfg_rdata  out  8  register read data, combinational on cfg_addr.
- lfsr_in  in  3  random symbol source.
- cpu_led_we  in  1  CPU LED write request.
- cpu_led_data  in  8  CPU LED value.
- led_sel  out  1  one-cycle LED load strobe to the LED register.
- led_data  out  8  LED value qualified by led_sel.
- busy  out  1  playback in progress.
- done  out  1  sticky playback-complete flag.

Function
REQ-003 Registers SHALL be: addr 0 CTRL (write: bit0 START, bit1 APPEND, bit2 CLEAR); addr 1 LEN (read: stored count); addr 2 STATUS (read: bit0 busy, bit1 done, bit2 full); addr 3 reads 0, writes ignored.
REQ-004 APPEND SHALL store lfsr_in at index LEN and increment LEN by 1.
- Ignored when LEN==DEPTH (full) or when busy.
REQ-005 CLEAR SHALL set LEN=0 and done=0.
- If busy: abort to IDLE and emit led_sel with led_data=0 on the next cycle.
REQ-006 A single CTRL write SHALL apply its bits in the order CLEAR, APPEND, START.
- APPEND+START plays the sequence including the new symbol.
- CLEAR+START plays an empty sequence.
REQ-007 The FSM SHALL have the states IDLE, ON, OFF and FIN.
- START in IDLE with LEN>0: ON at the next cycle with index 0, done=0, busy=1.
- START in IDLE with LEN==0: FIN.
- START while busy: ignored.
REQ-008 On entering ON, the block SHALL emit led_sel=1 for one cycle with led_data=1<<symbol[index] (one-hot), then hold for ON_TICKS ticks.
REQ-009 On entering OFF, the block SHALL emit led_sel=1 for one cycle with led_data=0, then hold for OFF_TICKS ticks.
- Then ON with index+1, or FIN when index==LEN-1.
REQ-010 FIN SHALL last one cycle, set done=1, then return to IDLE.
- done holds until the next START or CLEAR.
REQ-011 The tick prescaler SHALL restart at 0 on every state entry, so each ON/OFF phase lasts exactly N*TICK_DIV cycles.
REQ-012 Arbitration: in IDLE, cpu_led_we SHALL pass through same-cycle (led_sel=1, led_data=cpu_led_data).
- While busy, CPU LED writes are dropped.
- On the CLEAR-abort cycle the player's zero write wins.
REQ-013 Index and LEN SHALL be $clog2(DEPTH)+1 bits; index never wraps past LEN-1.

Reset
REQ-014 While rst is low, the block SHALL hold: state IDLE; LEN, index and prescaler 0; busy, done and led_sel 0; led_data 0.
- Symbol storage is not cleared.
REQ-015 Reset asserted mid-playback SHALL abort immediately with no led_sel pulse; the LED register is reset by its own reset.

Configuration
REQ-016 With XSEQ_LOOP_EN defined, CTRL bit3 (LOOP) SHALL be latched on START.
- In loop mode, FIN returns to ON at index 0 and does not set done.
- Only CLEAR or reset stops playback.
REQ-017 With XSEQ_LOOP_EN undefined, bit3 SHALL be ignored and no loop logic synthesised.

Structure
REQ-018 The shared defines include SHALL hold the register addresses, the CTRL/STATUS bit positions and the FSM state encodings.
REQ-019 The tick prescaler SHALL be one sub-module, xtick_gen (clk, rst, clr, tick).

Verification
REQ-020 The bench SHALL run with TICK_DIV=4, ON_TICKS=2 and OFF_TICKS=1, and SHALL cover:
- Reset, then APPEND x3 with lfsr_in=5,0,7, then START -> LEN=3; led_sel pulses 0x20, 0x00, 0x01, 0x00, 0x80, 0x00, spaced 8 and 4 cycles; then done=1, busy=0.
- START with LEN=0 -> no led_sel; done=1 two cycles after the write.
- 17 APPENDs with DEPTH=16 -> LEN=16, STATUS.full=1; 17th ignored.
- cpu_led_we=1, data 0xA5 while busy -> no led_sel from CPU; same write in IDLE -> led_sel with 0xA5 same cycle.
- CLEAR during ON -> next cycle led_sel with 0x00, busy=0, LEN=0, done=0; rst low mid-OFF -> all outputs 0 asynchronously.
- XSEQ_LOOP_EN with LOOP=1, LEN=2 -> symbol pattern repeats ≥3 times, done stays 0 until CLEAR.
